jtag_instruction_register_p: RTL and testbench

- Parametrised, fully synchronous JTAG instruction register for the TAP. Clocked on tck.
- Performs Capture-IR, Shift-IR and Update-IR under control of the 4-bit TAP state from the TAP controller.
- Decodes a programmable opcode table into a one-hot instruction bus for the data-register muxes.
- Adds lockable private instructions, a standard capture pattern with status bits, and a falling-edge-retimed tdo with enable.

---
 rtl/jtag_instruction_register_p_pkg.sv | 27 ++
 rtl/jtag_ir_decode.sv | 40 ++++
 rtl/jtag_instruction_register_p.sv | 131 +++++++++++++
 tb/tb_jtag_instruction_register_p.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/jtag_instruction_register_p_pkg.sv
// Shared TAP state codes, instruction index names and sizing helper for the
// JTAG instruction register and the logic that consumes its decoded bus.
package jtag_instruction_register_p_pkg;

  typedef enum logic [3:0] {
    exit1_ir_c         = 4'h9,
    shift_ir_c         = 4'hA,
    pause_ir_c         = 4'hB,
    update_ir_c        = 4'hD,
    capture_ir_c       = 4'hE,
    test_logic_reset_c = 4'hF
  } tap_state_e;

  typedef enum int unsigned {
    instr_bypass_c         = 0,
    instr_idcode_c         = 1,
    instr_sample_preload_c = 2,
    instr_extest_c         = 3,
    instr_intest_c         = 4,
    instr_program_c        = 5
  } instr_idx_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational opcode table lookup: lowest matching index, its private flag
// and a hit indication. Shared with the data-register select logic.
module jtag_ir_decode
  import jtag_instruction_register_p_pkg::*;
#(
  parameter int unsigned                   IR_LEN    = 4,
  parameter int unsigned                   INSTR_NUM = 6,
  parameter int unsigned                   IDX_W     = idx_width(INSTR_NUM),
  parameter logic [INSTR_NUM*IR_LEN-1:0]   OPCODES   = '0,
  parameter logic [INSTR_NUM-1:0]          PRIV_MASK = '0
) (
  input  logic [IR_LEN-1:0] code_i,
  output logic [IDX_W-1:0]  index_o,
  output logic              priv_o,
  output logic              hit_o
);

  logic [INSTR_NUM-1:0] match;

  generate
    for (genvar gi = 0; gi < INSTR_NUM; gi++) begin : g_match
      assign match[gi] = (OPCODES[gi*IR_LEN +: IR_LEN] == code_i);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    index_o = '0;
    priv_o  = 1'b0;
    hit_o   = 1'b0;
    for (int k = INSTR_NUM - 1; k >= 0; k--) begin
      if (match[k]) begin
        index_o = IDX_W'(k);
        priv_o  = PRIV_MASK[k];
        hit_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtag_instruction_register_p.sv
// JTAG instruction register: capture/shift/update on rising tck, one-hot
// instruction decode with private-instruction locking, falling-edge tdo.
module jtag_instruction_register_p
  import jtag_instruction_register_p_pkg::*;
#(
  parameter int unsigned                 IR_LEN      = 4,
  parameter int unsigned                 INSTR_NUM   = 6,
  parameter logic [INSTR_NUM*IR_LEN-1:0] OPCODES     = {4'b0101, 4'b0110, 4'b0000,
                                                        4'b0010, 4'b0001, 4'b1111},
  parameter logic [INSTR_NUM-1:0]        PRIV_MASK   = 6'b110000,
  parameter int unsigned                 RESET_INSTR = instr_idcode_c
) (
  input  logic                  tck,
  input  logic                  reset,
  input  logic                  tdi,
  input  logic [3:0]            state,
  input  logic [IR_LEN-3:0]     status,
  input  logic                  unlock,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [INSTR_NUM-1:0]  instr,
  output logic [IR_LEN-1:0]     instr_code,
  output logic                  priv_reject
);

  localparam int unsigned           IDX_W        = idx_width(INSTR_NUM);
  localparam int unsigned           BYPASS_IDX   = instr_bypass_c;
  localparam logic [INSTR_NUM-1:0]  INSTR_ONE    = INSTR_NUM'(1);
  localparam logic [INSTR_NUM-1:0]  RESET_ONEHOT = INSTR_ONE << RESET_INSTR;
  localparam logic [INSTR_NUM-1:0]  BYPASS_ONEHOT = INSTR_ONE << BYPASS_IDX;
  localparam logic [IR_LEN-1:0]     RESET_CODE   = OPCODES[RESET_INSTR*IR_LEN +: IR_LEN];
  localparam logic [IR_LEN-1:0]     BYPASS_CODE  = OPCODES[BYPASS_IDX*IR_LEN +: IR_LEN];
  localparam logic [IR_LEN-1:0]     SR_RESET     = IR_LEN'(1);

  logic [IR_LEN-1:0]    sr_q, sr_d;
  logic [INSTR_NUM-1:0] instr_q, instr_d;
  logic [IR_LEN-1:0]    instr_code_q, instr_code_d;
  logic                 priv_reject_q, priv_reject_d;
  logic                 tdo_q, tdo_en_q;

  logic [IR_LEN-1:0]    opcode_tab [INSTR_NUM];
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_priv;
  logic                 dec_hit;

  generate
    for (genvar gi = 0; gi < INSTR_NUM; gi++) begin : g_tab
      assign opcode_tab[gi] = OPCODES[gi*IR_LEN +: IR_LEN];
    end
  endgenerate

  jtag_ir_decode #(
    .IR_LEN    (IR_LEN),
    .INSTR_NUM (INSTR_NUM),
    .IDX_W     (IDX_W),
    .OPCODES   (OPCODES),
    .PRIV_MASK (PRIV_MASK)
  ) u_decode (
    .code_i  (sr_q),
    .index_o (dec_idx),
    .priv_o  (dec_priv),
    .hit_o   (dec_hit)
  );

  always_comb begin
    sr_d          = sr_q;
    instr_d       = instr_q;
    instr_code_d  = instr_code_q;
    priv_reject_d = priv_reject_q;
    case (state)
      test_logic_reset_c: begin
        sr_d          = SR_RESET;
        instr_d       = RESET_ONEHOT;
        instr_code_d  = RESET_CODE;
        priv_reject_d = 1'b0;
      end
      capture_ir_c: sr_d = {status, 2'b01};
      shift_ir_c:   sr_d = {tdi, sr_q[IR_LEN-1:1]};
      update_ir_c: begin
        // Unknown opcodes fall back to bypass without touching the sticky flag.
        if (!dec_hit) begin
          instr_d      = BYPASS_ONEHOT;
          instr_code_d = BYPASS_CODE;
        end else if (dec_priv && !unlock) begin
          instr_d       = BYPASS_ONEHOT;
          instr_code_d  = BYPASS_CODE;
          priv_reject_d = 1'b1;
        end else begin
          instr_d       = INSTR_ONE << dec_idx;
          instr_code_d  = opcode_tab[dec_idx];
          priv_reject_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!reset) begin
      sr_q          <= SR_RESET;
      instr_q       <= RESET_ONEHOT;
      instr_code_q  <= RESET_CODE;
      priv_reject_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      instr_q       <= instr_d;
      instr_code_q  <= instr_code_d;
      priv_reject_q <= priv_reject_d;
    end
  end

  // Retimed to the falling edge so tdo is stable around the next rising edge.
  always_ff @(negedge tck) begin
    if (!reset) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= (state == shift_ir_c);
      if (state == shift_ir_c) begin
        tdo_q <= sr_q[0];
      end
    end
  end

  assign tdo         = tdo_q;
  assign tdo_en      = tdo_en_q;
  assign instr       = instr_q;
  assign instr_code  = instr_code_q;
  assign priv_reject = priv_reject_q;

endmodule

// File: tb/tb_jtag_instruction_register_p.sv
// Directed and randomized scans of the instruction register, checked every
// half cycle against a behavioural IR model.
module tb_jtag_instruction_register_p;

  localparam logic [3:0] S_TLR   = 4'hF;
  localparam logic [3:0] S_CAP   = 4'hE;
  localparam logic [3:0] S_SHIFT = 4'hA;
  localparam logic [3:0] S_EXIT1 = 4'h9;
  localparam logic [3:0] S_PAUSE = 4'hB;
  localparam logic [3:0] S_UPD   = 4'hD;
  localparam logic [3:0] S_IDLE  = 4'hC;

  logic       tck = 1'b0;
  logic       reset = 1'b0;
  logic       tdi = 1'b0;
  logic [3:0] state = S_IDLE;
  logic [1:0] status = 2'b00;
  logic       unlock = 1'b0;
  logic       tdo, tdo_en, priv_reject;
  logic [5:0] instr;
  logic [3:0] instr_code;

  always #5 tck = ~tck;

  jtag_instruction_register_p dut (
    .tck         (tck),
    .reset       (reset),
    .tdi         (tdi),
    .state       (state),
    .status      (status),
    .unlock      (unlock),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .instr       (instr),
    .instr_code  (instr_code),
    .priv_reject (priv_reject)
  );

  // Opcode of each instruction index and whether it is locked.
  logic [3:0] op_tab   [6] = '{4'hF, 4'h1, 4'h2, 4'h0, 4'h6, 4'h5};
  bit         priv_tab [6] = '{0, 0, 0, 0, 1, 1};

  int unsigned sr_m  = 1;
  int unsigned idx_m = 1;
  bit          rej_m = 0;
  bit          tdo_m = 0;
  bit          en_m  = 0;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_rise(input logic rst, input logic [3:0] st, input logic d);
    int hit;
    if (!rst || st == S_TLR) begin
      sr_m  = 1;
      idx_m = 1;
      rej_m = 0;
    end else if (st == S_CAP) begin
      sr_m = status * 4 + 1;
    end else if (st == S_SHIFT) begin
      sr_m = sr_m / 2 + (d ? 8 : 0);
    end else if (st == S_UPD) begin
      hit = -1;
      for (int k = 0; k < 6; k++)
        if (hit < 0 && int'(op_tab[k]) == int'(sr_m)) hit = k;
      if (hit < 0) begin
        idx_m = 0;
      end else if (priv_tab[hit] && !unlock) begin
        idx_m = 0;
        rej_m = 1;
      end else begin
        idx_m = hit;
        rej_m = 0;
      end
    end
  endtask

  // One tck period: inputs change just after the rising edge, as a TAP would.
  task automatic tick(input logic rst, input logic [3:0] st, input logic d);
    reset = rst;
    state = st;
    tdi   = d;
    @(negedge tck);
    if (!rst) begin
      tdo_m = 0;
      en_m  = 0;
    end else begin
      en_m = (st == S_SHIFT);
      if (en_m) tdo_m = sr_m[0];
    end
    #1;
    expect_eq("tdo", tdo, tdo_m);
    expect_eq("tdo_en", tdo_en, en_m);
    @(posedge tck);
    model_rise(rst, st, d);
    #1;
    expect_eq("instr", instr, 32'd1 << idx_m);
    expect_eq("instr_code", instr_code, op_tab[idx_m]);
    expect_eq("priv_reject", priv_reject, rej_m);
  endtask

  task automatic scan(input logic [3:0] code, input bit upd);
    tick(1, S_CAP, 0);
    for (int i = 0; i < 4; i++) tick(1, S_SHIFT, code[i]);
    tick(1, S_EXIT1, 0);
    tick(1, S_PAUSE, 0);
    if (upd) tick(1, S_UPD, 0);
    tick(1, S_IDLE, 0);
    $display("scan code=%b unlock=%0b update=%0b -> instr=%b code=%b priv_reject=%0b",
             code, unlock, upd, instr, instr_code, priv_reject);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cap_bits;
    logic [3:0] code;
    int         mode;

    // Reset state.
    tick(0, S_IDLE, 0);
    tick(1, S_IDLE, 0);
    expect_eq("reset_instr", instr, 6'b000010);
    expect_eq("reset_code", instr_code, 4'b0001);
    expect_eq("reset_tdo_en", tdo_en, 1'b0);
    $display("reset -> instr=%b code=%b", instr, instr_code);

    // Capture pattern with status, shifted out LSB first.
    status   = 2'b10;
    cap_bits = 4'b1001;
    tick(1, S_CAP, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, S_SHIFT, 0);
      expect_eq("cap_tdo", tdo, cap_bits[i]);
      expect_eq("cap_tdo_en", tdo_en, 1'b1);
    end
    tick(1, S_EXIT1, 0);
    expect_eq("exit_tdo_en", tdo_en, 1'b0);
    tick(1, S_IDLE, 0);
    $display("capture status=%b shifted out LSB first", status);

    scan(4'b0010, 1);
    expect_eq("sample_preload", instr, 6'b000100);

    unlock = 0;
    scan(4'b0101, 1);
    expect_eq("prog_locked", instr, 6'b000001);
    expect_eq("prog_locked_rej", priv_reject, 1'b1);
    unlock = 1;
    scan(4'b0101, 1);
    expect_eq("prog_unlocked", instr, 6'b100000);
    expect_eq("prog_unlocked_rej", priv_reject, 1'b0);
    unlock = 0;
    tick(1, S_IDLE, 0);
    expect_eq("prog_persists", instr, 6'b100000);

    scan(4'b1010, 1);
    expect_eq("unknown_bypass", instr, 6'b000001);
    scan(4'b1111, 1);
    expect_eq("ones_bypass", instr, 6'b000001);
    expect_eq("ones_rej", priv_reject, 1'b0);

    // Reset mid-shift, then Test-Logic-Reset: 0110 must never take effect.
    tick(1, S_CAP, 0);
    tick(1, S_SHIFT, 0);
    tick(1, S_SHIFT, 1);
    tick(0, S_SHIFT, 1);
    tick(1, S_TLR, 0);
    expect_eq("tlr_instr", instr, 6'b000010);
    cap_bits = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick(1, S_SHIFT, 0);
      expect_eq("tlr_sr_bit", tdo, cap_bits[i]);
    end
    tick(1, S_IDLE, 0);
    expect_eq("tlr_no_update", instr, 6'b000010);
    $display("mid-shift reset and TLR -> instr=%b", instr);

    // Randomized scans with random unlock, status, tdi and interruptions.
    for (int n = 0; n < 60; n++) begin
      unlock = 1'($urandom_range(0, 1));
      status = 2'($urandom);
      code   = ($urandom_range(0, 9) < 6) ? op_tab[$urandom_range(0, 5)] : 4'($urandom);
      mode   = $urandom_range(0, 9);
      tick(1, S_CAP, 0);
      for (int i = 0; i < 4; i++) tick(1, S_SHIFT, code[i]);
      for (int p = $urandom_range(0, 2); p > 0; p--) tick(1, S_PAUSE, 1'($urandom));
      tick(1, S_EXIT1, 0);
      if (mode == 0)      tick(1, S_TLR, 0);
      else if (mode == 1) tick(0, S_UPD, 0);
      else                tick(1, S_UPD, 0);
      tick(1, S_IDLE, 1'($urandom));
      $display("rand %0d code=%b unlock=%0b mode=%0d -> instr=%b code=%b priv_reject=%0b",
               n, code, unlock, mode, instr, instr_code, priv_reject);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
